// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC angle path.
//   THETA_W    : angle width in degrees
//   DEG_FULL   : angle modulus (one full turn)
//   PERIOD_DEF : default hold length, matches the core's iteration latency
//   theta_t    : angle type
//   state_t    : sequencer states
package cordic_pkg;

    localparam int THETA_W    = 9;
    localparam int DEG_FULL   = 360;
    localparam int PERIOD_DEF = 18;

    typedef logic [THETA_W-1:0] theta_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/deg_wrap_add.sv
// Combinational modulo adder for degree angles.
//   a, b : operands, each already below MOD
//   sum  : (a + b) mod MOD
// The sum is formed one bit wider so a + b never overflows before the
// single conditional subtract; with both operands below MOD one subtract
// is always enough.
module deg_wrap_add #(
    parameter int W   = 9,
    parameter int MOD = 360
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam logic [W:0] MOD_V = (W+1)'(MOD);

    logic [W:0] raw;
    logic [W:0] red;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        red = raw - MOD_V;
        sum = (raw >= MOD_V) ? red[W-1:0] : raw[W-1:0];
    end

endmodule

// File: rtl/cordic_theta_seq.sv
// Angle sequencer feeding the CORDIC core's theta input.
// Issues a programmable sweep of angles, holding each for PERIOD cycles so
// the iterative core settles, and flags the cycle the core output is valid.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : request a sweep (acted on in IDLE only)
//   stop_i        : request a graceful end; the current hold still completes
//   start_theta_i : first angle, 0..DEG_FULL-1
//   step_i        : angle increment, 0..DEG_FULL-1
//   count_i       : number of angles; 0 runs until stop
//   theta_o       : angle to the core
//   theta_valid_o : pulse, theta_o took a new value this cycle
//   sample_o      : pulse, core output for theta_o is valid
//   busy_o        : high from first issued angle to end of last hold
//   done_o        : pulse, sweep finished
//   err_o         : pulse, start rejected for out-of-range parameters
module cordic_theta_seq
    import cordic_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEF,   // legal 2..255
    parameter int THETA_W  = cordic_pkg::THETA_W,
    parameter int DEG_FULL = cordic_pkg::DEG_FULL,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [THETA_W-1:0] start_theta_i,
    input  logic [THETA_W-1:0] step_i,
    input  logic [CNT_W-1:0]   count_i,
    output logic [THETA_W-1:0] theta_o,
    output logic               theta_valid_o,
    output logic               sample_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [7:0]         HOLD_LAST = 8'(PERIOD - 1);
    localparam logic [THETA_W-1:0] DEG_LIM   = THETA_W'(DEG_FULL);

    state_t             state_q, state_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [THETA_W-1:0] step_q, step_d;
    logic [THETA_W-1:0] theta_q, theta_d;
    logic               stop_pend_q, stop_pend_d;
    logic               err_q, err_d;
    logic [THETA_W-1:0] theta_next;
    logic               params_ok;
    logic               last_hold;
    logic               sweep_end;

    deg_wrap_add #(
        .W   (THETA_W),
        .MOD (DEG_FULL)
    ) u_wrap (
        .a   (theta_q),
        .b   (step_q),
        .sum (theta_next)
    );

    assign params_ok = (start_theta_i < DEG_LIM) && (step_i < DEG_LIM);
    assign last_hold = (hold_cnt_q == HOLD_LAST);
    // A stop arriving on the final hold cycle is honoured immediately so
    // no further angle slips out after it.
    assign sweep_end = stop_pend_q || stop_i ||
                       ((count_q != '0) && (issued_q == count_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            issued_q    <= '0;
            count_q     <= '0;
            step_q      <= '0;
            theta_q     <= '0;
            stop_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            issued_q    <= issued_d;
            count_q     <= count_d;
            step_q      <= step_d;
            theta_q     <= theta_d;
            stop_pend_q <= stop_pend_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        issued_d    = issued_q;
        count_d     = count_q;
        step_d      = step_q;
        theta_d     = theta_q;
        stop_pend_d = stop_pend_q;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // stop wins over a simultaneous start, including bad params
                if (start_i && !stop_i) begin
                    if (params_ok) begin
                        step_d     = step_i;
                        count_d    = count_i;
                        theta_d    = start_theta_i;
                        hold_cnt_d = '0;
                        issued_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d    = HOLD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (stop_i) stop_pend_d = 1'b1;
                if (last_hold) begin
                    if (sweep_end) begin
                        state_d = FIN;
                    end else begin
                        theta_d    = theta_next;
                        hold_cnt_d = '0;
                        // only reachable saturated in continuous mode
                        if (issued_q != '1) issued_d = issued_q + 1'b1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            FIN: begin
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign theta_o       = theta_q;
    assign theta_valid_o = (state_q == HOLD) && (hold_cnt_q == 8'd0);
    assign sample_o      = (state_q == HOLD) && last_hold;
    assign busy_o        = (state_q == HOLD);
    assign done_o        = (state_q == FIN);
    assign err_o         = err_q;

endmodule

// File: tb/tb_cordic_theta_seq.sv
// Directed bench for cordic_theta_seq: expected angles are queued when a
// sweep is launched and popped on every theta_valid_o pulse.
module tb_cordic_theta_seq;

    localparam int PERIOD = 18;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        stop_i;
    logic [8:0]  start_theta_i;
    logic [8:0]  step_i;
    logic [15:0] count_i;
    logic [8:0]  theta_o;
    logic        theta_valid_o;
    logic        sample_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    cordic_theta_seq #(.PERIOD(PERIOD)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .start_theta_i (start_theta_i),
        .step_i        (step_i),
        .count_i       (count_i),
        .theta_o       (theta_o),
        .theta_valid_o (theta_valid_o),
        .sample_o      (sample_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_valid, n_sample, n_done, n_err;
    int first_valid_cyc, last_valid_cyc, done_cyc;
    int exp_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_sample = 0; n_done = 0; n_err = 0;
        first_valid_cyc = -1; last_valid_cyc = -1; done_cyc = -1;
    endtask

    // Advance one clock, then observe outputs 1 time unit after the edge.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        cyc++;
        if (theta_valid_o) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("theta_value", int'(theta_o), e);
            if (last_valid_cyc >= 0) chk("valid_spacing", cyc - last_valid_cyc, PERIOD);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_valid_cyc = cyc;
            n_valid++;
        end
        if (sample_o) begin
            chk("sample_offset", cyc - last_valid_cyc, PERIOD - 1);
            n_sample++;
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (err_o) n_err++;
    endtask

    task automatic push_sweep(input int s, input int st, input int n);
        int th = s;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(th);
            th = (th + st) % 360;
        end
    endtask

    task automatic launch(input int s, input int st, input int c);
        start_theta_i = 9'(s);
        step_i        = 9'(st);
        count_i       = 16'(c);
        start_i       = 1'b1;
        tick();
        start_i       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            tick();
            n++;
        end
        chk("done_within_budget", int'(done_o), 1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"},  int'(theta_valid_o), 0);
        chk({tag, "_sample"}, int'(sample_o), 0);
        chk({tag, "_busy"},   int'(busy_o), 0);
        chk({tag, "_done"},   int'(done_o), 0);
        chk({tag, "_err"},    int'(err_o), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        start_theta_i = '0; step_i = '0; count_i = '0;
        clear_stats();
        repeat (3) tick();
        check_quiet("reset");
        chk("reset_theta", int'(theta_o), 0);
        rst = 1'b0;
        tick();

        // full 360-angle sweep
        clear_stats();
        push_sweep(0, 1, 360);
        launch(0, 1, 360);
        chk("first_valid_latency", int'(theta_valid_o), 1);
        chk("first_busy", int'(busy_o), 1);
        wait_done(7000);
        chk("full_valid_count", n_valid, 360);
        chk("full_sample_count", n_sample, 360);
        chk("full_done_offset", done_cyc - first_valid_cyc, 6480);
        chk("full_done_busy", int'(busy_o), 0);
        chk("full_last_theta", int'(theta_o), 359);
        chk("full_queue_empty", exp_q.size(), 0);
        tick();
        chk("full_done_pulse", int'(done_o), 0);

        // wrap, with a start request mid-sweep that must be ignored
        clear_stats();
        push_sweep(350, 7, 4);
        launch(350, 7, 4);
        start_theta_i = 9'd0; step_i = 9'd1; count_i = 16'd0; start_i = 1'b1;
        repeat (30) tick();
        start_i = 1'b0;
        wait_done(200);
        chk("wrap_valid_count", n_valid, 4);
        chk("wrap_last_theta", int'(theta_o), 11);
        chk("wrap_queue_empty", exp_q.size(), 0);
        repeat (3) tick();
        chk("wrap_no_restart", n_valid, 4);

        // step of zero repeats the angle
        clear_stats();
        push_sweep(5, 0, 3);
        launch(5, 0, 3);
        wait_done(200);
        chk("step0_valid_count", n_valid, 3);
        chk("step0_queue_empty", exp_q.size(), 0);
        tick();

        // continuous mode, stop on the 5th cycle of the third hold
        clear_stats();
        push_sweep(0, 90, 3);
        launch(0, 90, 0);
        n = 0;
        while (n_valid < 3 && n < 200) begin
            tick();
            n++;
        end
        chk("cont_third_valid", n_valid, 3);
        repeat (4) tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        wait_done(100);
        chk("cont_valid_count", n_valid, 3);
        chk("cont_sample_count", n_sample, 3);
        chk("cont_done_offset", done_cyc - last_valid_cyc, PERIOD);
        chk("cont_last_theta", int'(theta_o), 180);
        chk("cont_queue_empty", exp_q.size(), 0);
        tick();

        // rejected parameters
        clear_stats();
        start_theta_i = 9'd10; step_i = 9'd360; count_i = 16'd4; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("err_step_pulse", int'(err_o), 1);
        chk("err_step_busy", int'(busy_o), 0);
        chk("err_step_theta", int'(theta_o), 180);
        tick();
        chk("err_step_clear", int'(err_o), 0);
        start_theta_i = 9'd360; step_i = 9'd1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("err_theta_pulse", int'(err_o), 1);
        chk("err_theta_busy", int'(busy_o), 0);
        tick();
        chk("err_valid_count", n_valid, 0);

        // start and stop together: nothing happens
        clear_stats();
        start_theta_i = 9'd20; step_i = 9'd5; count_i = 16'd2;
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        check_quiet("startstop");
        tick();
        chk("startstop_valid_count", n_valid, 0);
        chk("startstop_err_count", n_err, 0);

        // reset at hold_cnt 9 of the second angle
        clear_stats();
        push_sweep(100, 10, 2);
        launch(100, 10, 0);
        n = 0;
        while (n_valid < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_second_valid", n_valid, 2);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("midreset");
        chk("midreset_theta", int'(theta_o), 0);
        exp_q.delete();
        repeat (3) tick();
        chk("midreset_no_done", n_done, 0);
        clear_stats();
        push_sweep(45, 1, 2);
        launch(45, 1, 2);
        wait_done(100);
        chk("fresh_valid_count", n_valid, 2);
        chk("fresh_last_theta", int'(theta_o), 46);
        chk("fresh_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
